axil_reg_seq_checker: RTL and testbench

- Synthesizable AXI4-Lite master that replaces the simulation-only register write/read-back check with on-chip hardware.
- On `start`, writes a parametrised data pattern to NUM_REGS registers, then reads each one back and compares it.
- Reports pass/fail, error count, first failing index and a watchdog timeout.
- Sits in the block design next to the slave under test; its status lines go to a VIO/ILA or a status register.

---
 rtl/axil_reg_seq_checker.sv | 141 ++++++++++++++
 tb/tb_axil_reg_seq_checker.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_seq_checker.sv
// axil_reg_seq_checker: AXI4-Lite master that writes a pattern to NUM_REGS registers, reads each back and reports errors.
// Runs one transaction at a time. A watchdog is applied to every handshake phase.
module axil_reg_seq_checker #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int ADDR_STRIDE = 4,
  parameter int SEED = 1,
  parameter int PATTERN_MODE = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic                            timeout,
  output logic [15:0]                     err_count,
  output logic [7:0]                      first_err_idx,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;
  state_t state, nxt;
  logic [7:0] idx;
  logic [31:0] wd;
  logic aw_done, w_done, wr_fin, adv, waiting, last, to_ev, err_ev, start_ok;
  logic [AW-1:0] addr;
  logic [DW-1:0] sum, exp_data;
  assign addr = BASE_ADDR + AW'(idx) * AW'(ADDR_STRIDE);
  assign sum = DW'(SEED) + DW'(idx);
  assign exp_data = (PATTERN_MODE != 0) ? ~sum : sum;
  assign M_AXI_AWADDR = addr;
  assign M_AXI_ARADDR = addr;
  assign M_AXI_WDATA = exp_data;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB = '1;
  assign M_AXI_AWVALID = (state == WR_REQ) && !aw_done;
  assign M_AXI_WVALID = (state == WR_REQ) && !w_done;
  assign M_AXI_BREADY = (state == WR_RESP);
  assign M_AXI_ARVALID = (state == RD_REQ);
  assign M_AXI_RREADY = (state == RD_RESP);
  assign busy = waiting;
  assign done = (state == DONE);
  assign waiting = state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
  assign last = (idx == 8'(NUM_REGS - 1));
  assign start_ok = start && (state == IDLE || state == DONE);
  // each write channel retires on its own handshake; the phase ends when both have
  assign wr_fin = (aw_done || (M_AXI_AWVALID && M_AXI_AWREADY)) && (w_done || (M_AXI_WVALID && M_AXI_WREADY));
  assign err_ev = (state == WR_RESP && M_AXI_BVALID && M_AXI_BRESP != 2'b00) ||
                  (state == RD_RESP && M_AXI_RVALID && (M_AXI_RDATA != exp_data || M_AXI_RRESP != 2'b00));
  always_comb begin
    nxt = state;
    adv = 1'b0;
    case (state)
      IDLE, DONE: nxt = start ? WR_REQ : state;
      WR_REQ: begin
        adv = wr_fin;
        nxt = adv ? WR_RESP : state;
      end
      WR_RESP: begin
        adv = M_AXI_BVALID;
        nxt = !adv ? state : last ? RD_REQ : WR_REQ;
      end
      RD_REQ: begin
        adv = M_AXI_ARREADY;
        nxt = adv ? RD_RESP : state;
      end
      RD_RESP: begin
        adv = M_AXI_RVALID;
        nxt = !adv ? state : last ? DONE : RD_REQ;
      end
      default: nxt = IDLE;
    endcase
    to_ev = waiting && !adv && (wd == 32'(TIMEOUT_CYCLES - 1));
    if (to_ev) nxt = DONE;
  end
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state <= IDLE;
      idx <= '0;
      wd <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      pass <= 1'b0;
      timeout <= 1'b0;
      err_count <= '0;
      first_err_idx <= '0;
    end else begin
      state <= nxt;
      wd <= (nxt != state) ? '0 : wd + 32'd1;
      if (start_ok) begin
        idx <= '0;
        aw_done <= 1'b0;
        w_done <= 1'b0;
        pass <= 1'b0;
        timeout <= 1'b0;
        err_count <= '0;
        first_err_idx <= '0;
      end else begin
        if (to_ev) timeout <= 1'b1;
        if (err_ev) begin
          if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          if (err_count == 16'd0) first_err_idx <= idx;
        end
        if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done <= 1'b1;
        if (M_AXI_WVALID && M_AXI_WREADY) w_done <= 1'b1;
        if (state == WR_RESP && M_AXI_BVALID) begin
          aw_done <= 1'b0;
          w_done <= 1'b0;
          idx <= last ? 8'd0 : idx + 8'd1;
        end
        if (state == RD_RESP && M_AXI_RVALID && !last) idx <= idx + 8'd1;
        // pass is frozen on entry to DONE, folding in this cycle's error/timeout
        if (nxt == DONE && state != DONE) pass <= !to_ev && !err_ev && (err_count == 16'd0);
      end
    end
  end
endmodule

// File: tb/tb_axil_reg_seq_checker.sv
// tb_axil_reg_seq_checker: two checker instances (4-reg and 16-reg variants) against a reactive AXI4-Lite slave.
// Expected results come from a per-register model of the pattern, addresses and injected faults.
module tb_axil_reg_seq_checker;
  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;
  logic start[2];
  logic busy[2], done[2], pass[2], timeout[2];
  logic [15:0] err_count[2];
  logic [7:0] first_err_idx[2];
  logic [31:0] awaddr[2], wdata[2], araddr[2], rdata[2];
  logic [2:0] awprot[2], arprot[2];
  logic [3:0] wstrb[2];
  logic [1:0] bresp[2], rresp[2];
  logic awvalid[2], awready[2], wvalid[2], wready[2], bvalid[2], bready[2];
  logic arvalid[2], arready[2], rvalid[2], rready[2];
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [31:0] err_wr, err_rd, bad_rd;
  logic have_aw[2], have_w[2], have_ar[2];
  logic [31:0] s_awaddr[2], s_wdata[2], s_araddr[2];
  int c_aw[2], c_w[2], c_b[2], c_ar[2], c_r[2];
  logic [31:0] mem[2][64];
  int wl_n[2];
  logic [31:0] wl_a[2][64], wl_d[2][64];
  int n_cmp = 0;
  int n_bad = 0;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      axil_reg_seq_checker #(
        .NUM_REGS(g ? 16 : 4), .ADDR_STRIDE(g ? 8 : 4), .SEED(g ? 5 : 1),
        .PATTERN_MODE(g), .TIMEOUT_CYCLES(g ? 1024 : 16)
      ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start[g]), .busy(busy[g]), .done(done[g]),
        .pass(pass[g]), .timeout(timeout[g]), .err_count(err_count[g]), .first_err_idx(first_err_idx[g]),
        .M_AXI_AWADDR(awaddr[g]), .M_AXI_AWPROT(awprot[g]), .M_AXI_AWVALID(awvalid[g]), .M_AXI_AWREADY(awready[g]),
        .M_AXI_WDATA(wdata[g]), .M_AXI_WSTRB(wstrb[g]), .M_AXI_WVALID(wvalid[g]), .M_AXI_WREADY(wready[g]),
        .M_AXI_BRESP(bresp[g]), .M_AXI_BVALID(bvalid[g]), .M_AXI_BREADY(bready[g]),
        .M_AXI_ARADDR(araddr[g]), .M_AXI_ARPROT(arprot[g]), .M_AXI_ARVALID(arvalid[g]), .M_AXI_ARREADY(arready[g]),
        .M_AXI_RDATA(rdata[g]), .M_AXI_RRESP(rresp[g]), .M_AXI_RVALID(rvalid[g]), .M_AXI_RREADY(rready[g])
      );
    end
  endgenerate

  // slave: each ready/valid rises once its channel has waited the programmed number of cycles
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      awready[g] = awvalid[g] && c_aw[g] >= aw_dly;
      wready[g] = wvalid[g] && c_w[g] >= w_dly;
      bvalid[g] = have_aw[g] && have_w[g] && c_b[g] >= b_dly;
      bresp[g] = (s_awaddr[g] == err_wr) ? 2'b10 : 2'b00;
      arready[g] = arvalid[g] && c_ar[g] >= ar_dly;
      rvalid[g] = have_ar[g] && c_r[g] >= r_dly;
      rdata[g] = (s_araddr[g] == bad_rd) ? 32'hDEAD : mem[g][s_araddr[g][7:2]];
      rresp[g] = (s_araddr[g] == err_rd) ? 2'b10 : 2'b00;
    end
  end

  always @(posedge ACLK) begin
    for (int g = 0; g < 2; g++) begin
      if (!ARESETN) begin
        have_aw[g] <= 1'b0; have_w[g] <= 1'b0; have_ar[g] <= 1'b0;
        c_aw[g] <= 0; c_w[g] <= 0; c_b[g] <= 0; c_ar[g] <= 0; c_r[g] <= 0;
        wl_n[g] <= 0;
      end else begin
        c_aw[g] <= (awvalid[g] && !awready[g]) ? c_aw[g] + 1 : 0;
        c_w[g] <= (wvalid[g] && !wready[g]) ? c_w[g] + 1 : 0;
        c_ar[g] <= (arvalid[g] && !arready[g]) ? c_ar[g] + 1 : 0;
        c_b[g] <= (have_aw[g] && have_w[g] && !(bvalid[g] && bready[g])) ? c_b[g] + 1 : 0;
        c_r[g] <= (have_ar[g] && !(rvalid[g] && rready[g])) ? c_r[g] + 1 : 0;
        if (awvalid[g] && awready[g]) begin have_aw[g] <= 1'b1; s_awaddr[g] <= awaddr[g]; end
        if (wvalid[g] && wready[g]) begin have_w[g] <= 1'b1; s_wdata[g] <= wdata[g]; end
        if (bvalid[g] && bready[g]) begin
          have_aw[g] <= 1'b0; have_w[g] <= 1'b0;
          mem[g][s_awaddr[g][7:2]] <= s_wdata[g];
          if (wl_n[g] < 64) begin wl_a[g][wl_n[g]] <= s_awaddr[g]; wl_d[g][wl_n[g]] <= s_wdata[g]; end
          wl_n[g] <= wl_n[g] + 1;
        end
        if (arvalid[g] && arready[g]) begin have_ar[g] <= 1'b1; s_araddr[g] <= araddr[g]; end
        if (rvalid[g] && rready[g]) have_ar[g] <= 1'b0;
        if (start[g] && !busy[g]) wl_n[g] <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input int s, input string tag);
    chk({tag, "_flags"}, 32'({busy[s], done[s], pass[s], timeout[s], awvalid[s], wvalid[s], bready[s], arvalid[s], rready[s]}), 0);
    chk({tag, "_err_count"}, 32'(err_count[s]), 0);
    chk({tag, "_first_err_idx"}, 32'(first_err_idx[s]), 0);
    chk({tag, "_prot_strb"}, 32'({awprot[s], arprot[s], wstrb[s]}), 32'h00F);
  endtask

  // pulses start, then follows the run to done, checking hold/drop rules on every handshake
  task automatic run(input int s, output int lat);
    logic aw_st, w_st, ar_st, aw_hs, w_hs, ar_hs;
    logic [31:0] aw_a, w_d, ar_a;
    @(negedge ACLK);
    start[s] = 1'b1;
    @(posedge ACLK);
    #1;
    start[s] = 1'b0;
    lat = 1;
    chk("valids_after_start", 32'({awvalid[s], wvalid[s], busy[s], done[s]}), 32'b1110);
    while (!done[s] && lat < 5000) begin
      aw_st = awvalid[s] && !awready[s]; w_st = wvalid[s] && !wready[s]; ar_st = arvalid[s] && !arready[s];
      aw_hs = awvalid[s] && awready[s]; w_hs = wvalid[s] && wready[s]; ar_hs = arvalid[s] && arready[s];
      aw_a = awaddr[s]; w_d = wdata[s]; ar_a = araddr[s];
      @(posedge ACLK);
      #1;
      lat++;
      if (aw_st && !timeout[s]) chk("aw_hold", {awvalid[s], awaddr[s][30:0]}, {1'b1, aw_a[30:0]});
      if (w_st && !timeout[s]) chk("w_hold", {wvalid[s], wdata[s][30:0]}, {1'b1, w_d[30:0]});
      if (ar_st && !timeout[s]) chk("ar_hold", {arvalid[s], araddr[s][30:0]}, {1'b1, ar_a[30:0]});
      if (aw_hs) chk("aw_drop", 32'(awvalid[s]), 0);
      if (w_hs) chk("w_drop", 32'(wvalid[s]), 0);
      if (ar_hs) chk("ar_drop", 32'(arvalid[s]), 0);
    end
    chk("run_bound", 32'(done[s]), 1);
  endtask

  task automatic check_model(input int s, input bit exp_to);
    int nr, stride, ecnt, first;
    logic [31:0] a, d;
    nr = s ? 16 : 4;
    stride = s ? 8 : 4;
    ecnt = 0;
    first = -1;
    for (int i = 0; i < nr; i++) begin
      a = 32'(i * stride);
      d = s ? ~(32'(5 + i)) : 32'(1 + i);
      if (a == err_wr) begin ecnt++; if (first < 0) first = i; end
      chk("wlog_addr", wl_a[s][i], a);
      chk("wlog_data", wl_d[s][i], d);
    end
    if (!exp_to)
      for (int i = 0; i < nr; i++) begin
        a = 32'(i * stride);
        if (a == bad_rd || a == err_rd) begin ecnt++; if (first < 0) first = i; end
      end
    chk("wlog_count", 32'(wl_n[s]), 32'(nr));
    chk("err_count", 32'(err_count[s]), 32'(ecnt));
    chk("first_err_idx", 32'(first_err_idx[s]), first < 0 ? 0 : 32'(first));
    chk("pass", 32'(pass[s]), 32'(ecnt == 0 && !exp_to));
    chk("timeout", 32'(timeout[s]), 32'(exp_to));
    chk("done_busy", 32'({done[s], busy[s]}), 32'b10);
  endtask

  task automatic knobs(input int aw, input int w, input int b, input int ar, input int r);
    aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    err_wr = '1; err_rd = '1; bad_rd = '1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  initial begin
    int lat, k, s, nr, st;
    start[0] = 1'b0;
    start[1] = 1'b0;
    knobs(0, 0, 0, 0, 0);
    repeat (3) @(posedge ACLK);
    #1;
    chk_idle(0, "reset_a");
    chk_idle(1, "reset_b");
    @(negedge ACLK);
    ARESETN = 1'b1;

    run(0, lat);
    chk("zero_wait_latency", 32'(lat), 17);
    check_model(0, 0);

    knobs(3, 0, 0, 0, 0);
    run(0, lat);
    check_model(0, 0);

    knobs(0, 0, 0, 0, 0);
    bad_rd = 32'h8;
    run(0, lat);
    check_model(0, 0);
    chk("bad_read_first_idx", 32'(first_err_idx[0]), 2);

    knobs(0, 0, 0, 0, 0);
    err_wr = 32'h0;
    err_rd = 32'hC;
    run(0, lat);
    check_model(0, 0);
    chk("slverr_count", 32'(err_count[0]), 2);

    knobs(0, 0, 0, 1000, 0);
    run(0, lat);
    chk("timeout_latency", 32'(lat), 25);
    chk("timeout_arvalid", 32'(arvalid[0]), 0);
    check_model(0, 1);

    knobs(0, 0, 0, 0, 0);
    run(1, lat);
    chk("b_zero_wait_latency", 32'(lat), 65);
    check_model(1, 0);

    // abort instance b mid-sequence at write 7, then rerun it cleanly
    err_wr = 32'h8;
    @(negedge ACLK);
    start[1] = 1'b1;
    @(posedge ACLK);
    #1;
    start[1] = 1'b0;
    k = 0;
    while (!(awvalid[1] && awaddr[1] == 32'd56) && k < 200) begin
      @(posedge ACLK);
      #1;
      k++;
    end
    chk("reach_write7", 32'(awvalid[1] && awaddr[1] == 32'd56), 1);
    chk("pre_reset_err", 32'(err_count[1]), 1);
    @(negedge ACLK);
    ARESETN = 1'b0;
    @(posedge ACLK);
    #1;
    chk_idle(1, "midrun_reset");
    @(negedge ACLK);
    ARESETN = 1'b1;
    err_wr = '1;
    run(1, lat);
    check_model(1, 0);

    for (int it = 0; it < 12; it++) begin
      s = int'($urandom_range(0, 1));
      nr = s ? 16 : 4;
      st = s ? 8 : 4;
      knobs(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) err_wr = 32'(int'($urandom_range(0, nr - 1)) * st);
      if ($urandom_range(0, 2) == 0) err_rd = 32'(int'($urandom_range(0, nr - 1)) * st);
      if ($urandom_range(0, 2) == 0) bad_rd = 32'(int'($urandom_range(0, nr - 1)) * st);
      run(s, lat);
      check_model(s, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
